// File: rtl/x_skew_feeder.sv
// Diagonal skew feeder for the systolic array's left edge: lane r of each accepted
// X vector reaches row r after r+1 advances, with tile-boundary tracking.
module x_skew_feeder #(
    parameter int DWIDTH = 16,
    parameter int ROWS   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ROWS*DWIDTH-1:0]   in_vec,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic                     out_ready,
    output logic [ROWS*DWIDTH-1:0]   x_out,
    output logic [ROWS-1:0]          x_valid,
    output logic [ROWS-1:0]          x_last,
    output logic                     busy,
    output logic                     tile_done,
    output logic [15:0]              vec_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic        tile_done_q, tile_done_d;
    logic [15:0] vec_cnt_q, vec_cnt_d;
    logic        acc;
    logic        final_last_in;

    assign in_ready = out_ready & (state_q != DRAIN);
    assign acc      = in_valid & in_ready;

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [r:0][DWIDTH-1:0] data_q, data_d;
        logic [r:0]             valid_q, valid_d;
        logic [r:0]             last_q, last_d;
        logic [DWIDTH-1:0]      head;

        // Bubbles keep the previous stage-0 data so the data path only toggles on accepts.
        assign head = acc ? in_vec[r*DWIDTH +: DWIDTH] : data_q[0];

        if (r == 0) begin : g_one
            always_comb begin
                data_d  = data_q;
                valid_d = valid_q;
                last_d  = last_q;
                if (out_ready) begin
                    data_d  = head;
                    valid_d = acc;
                    last_d  = acc & in_last;
                end
            end
        end else begin : g_chain
            always_comb begin
                data_d  = data_q;
                valid_d = valid_q;
                last_d  = last_q;
                if (out_ready) begin
                    data_d  = {data_q[r-1:0], head};
                    valid_d = {valid_q[r-1:0], acc};
                    last_d  = {last_q[r-1:0], acc & in_last};
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= '0;
                last_q  <= '0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
                last_q  <= last_d;
            end
        end

        assign x_out[r*DWIDTH +: DWIDTH] = data_q[r];
        assign x_valid[r]                = valid_q[r];
        assign x_last[r]                 = last_q[r];
    end

    // last is only ever set together with valid, so last alone marks the tile end.
    assign final_last_in = out_ready & g_lane[ROWS-1].last_d[ROWS-1];

    always_comb begin
        state_d     = state_q;
        vec_cnt_d   = vec_cnt_q;
        tile_done_d = final_last_in;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    vec_cnt_d = 16'd1;
                    state_d   = in_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (acc) begin
                    if (vec_cnt_q != '1) begin
                        vec_cnt_d = vec_cnt_q + 16'd1;
                    end
                    if (in_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (tile_done_q) begin
                    state_d   = IDLE;
                    vec_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tile_done_q <= 1'b0;
            vec_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tile_done_q <= tile_done_d;
            vec_cnt_q   <= vec_cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign tile_done = tile_done_q;
    assign vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_x_skew_feeder.sv
// Directed bench for x_skew_feeder (ROWS=4, DWIDTH=16): skew latency, bubbles,
// stalls, drain blocking, single-vector tiles and asynchronous reset.
module tb_x_skew_feeder;

    localparam int DW = 16;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NR*DW-1:0]  in_vec = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              out_ready = 1'b1;
    logic [NR*DW-1:0]  x_out;
    logic [NR-1:0]     x_valid;
    logic [NR-1:0]     x_last;
    logic              busy;
    logic              tile_done;
    logic [15:0]       vec_cnt;

    int checks = 0;
    int errors = 0;

    x_skew_feeder #(.DWIDTH(DW), .ROWS(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .x_out     (x_out),
        .x_valid   (x_valid),
        .x_last    (x_last),
        .busy      (busy),
        .tile_done (tile_done),
        .vec_cnt   (vec_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] v4(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] v, input logic vld, input logic lst);
        in_vec   = v;
        in_valid = vld;
        in_last  = lst;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Two-vector tile with out_ready held high; starts and ends in IDLE.
    task automatic run_basic(input string p);
        drive(v4(1, 2, 3, 4), 1'b1, 1'b0);
        step();
        chk({p, "_row0_first"}, 64'(x_out[15:0]), 64'd1);
        chk({p, "_valid_e1"}, 64'(x_valid), 64'b0001);
        chk({p, "_busy_e1"}, 64'(busy), 64'd1);
        drive(v4(5, 6, 7, 8), 1'b1, 1'b1);
        step();
        chk({p, "_row0_second"}, 64'(x_out[15:0]), 64'd5);
        chk({p, "_row1_first"}, 64'(x_out[31:16]), 64'd2);
        chk({p, "_valid_e2"}, 64'(x_valid), 64'b0011);
        chk({p, "_last_e2"}, 64'(x_last), 64'b0001);
        chk({p, "_inrdy_e2"}, 64'(in_ready), 64'd0);
        idle();
        step();
        chk({p, "_valid_e3"}, 64'(x_valid), 64'b0110);
        step();
        chk({p, "_xout_e4"}, x_out, v4(5, 6, 7, 4));
        chk({p, "_valid_e4"}, 64'(x_valid), 64'b1100);
        chk({p, "_cnt_e4"}, 64'(vec_cnt), 64'd2);
        chk({p, "_done_e4"}, 64'(tile_done), 64'd0);
        step();
        chk({p, "_xout_e5"}, x_out, v4(5, 6, 7, 8));
        chk({p, "_valid_e5"}, 64'(x_valid), 64'b1000);
        chk({p, "_last_e5"}, 64'(x_last), 64'b1000);
        chk({p, "_done_e5"}, 64'(tile_done), 64'd1);
        chk({p, "_cnt_e5"}, 64'(vec_cnt), 64'd2);
        chk({p, "_inrdy_e5"}, 64'(in_ready), 64'd0);
        step();
        chk({p, "_done_e6"}, 64'(tile_done), 64'd0);
        chk({p, "_busy_e6"}, 64'(busy), 64'd0);
        chk({p, "_cnt_e6"}, 64'(vec_cnt), 64'd0);
        chk({p, "_inrdy_e6"}, 64'(in_ready), 64'd1);
        chk({p, "_valid_e6"}, 64'(x_valid), 64'd0);
    endtask

    // Counts advances until tile_done; an expired budget reads back as an impossible count.
    task automatic wait_done(input string tag, input int exp_steps);
        int n;
        n = 0;
        while (tile_done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, 64'(n), 64'(exp_steps));
    endtask

    initial begin
        logic [3:0] bub_v [7];
        int         pulses;
        bub_v = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000, 4'b0000};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_xout", x_out, 64'd0);
        chk("rst_valid", 64'(x_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(vec_cnt), 64'd0);
        #9 rst_n = 1'b1;
        step();

        // Combinational in_ready under a stall with valid input
        out_ready = 1'b0;
        drive(v4(7, 7, 7, 7), 1'b1, 1'b0);
        #1;
        chk("stall_idle_inrdy", 64'(in_ready), 64'd0);
        step();
        chk("stall_idle_noacc", 64'(busy), 64'd0);
        idle();
        out_ready = 1'b1;
        #1;
        chk("idle_inrdy", 64'(in_ready), 64'd1);
        step();

        // Skew and latency
        run_basic("s1");

        // Bubble between the two vectors
        drive(v4(1, 1, 1, 1), 1'b1, 1'b0);
        step();
        chk("bub_valid_f1", 64'(x_valid), 64'(bub_v[0]));
        idle();
        step();
        chk("bub_valid_f2", 64'(x_valid), 64'(bub_v[1]));
        chk("bub_row0_hold", 64'(x_out[15:0]), 64'd1);
        drive(v4(2, 2, 2, 2), 1'b1, 1'b1);
        step();
        chk("bub_valid_f3", 64'(x_valid), 64'(bub_v[2]));
        idle();
        for (int i = 3; i < 7; i++) begin
            step();
            chk($sformatf("bub_valid_f%0d", i + 1), 64'(x_valid), 64'(bub_v[i]));
            chk($sformatf("bub_done_f%0d", i + 1), 64'(tile_done), 64'(i == 5));
        end
        chk("bub_xout_end", x_out, v4(2, 2, 2, 2));
        chk("bub_busy_end", 64'(busy), 64'd0);

        // Three-cycle stall mid-tile with a valid vector waiting
        drive(v4(1, 2, 3, 4), 1'b1, 1'b0);
        step();
        out_ready = 1'b0;
        drive(v4(5, 6, 7, 8), 1'b1, 1'b1);
        #1;
        chk("stall_inrdy", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_xout_%0d", i), x_out, v4(1, 2, 2, 2));
            chk($sformatf("stall_valid_%0d", i), 64'(x_valid), 64'b0001);
            chk($sformatf("stall_cnt_%0d", i), 64'(vec_cnt), 64'd1);
        end
        out_ready = 1'b1;
        step();
        chk("stall_xout_g5", x_out, v4(5, 2, 2, 2));
        chk("stall_valid_g5", 64'(x_valid), 64'b0011);
        idle();
        step();
        chk("stall_valid_g6", 64'(x_valid), 64'b0110);
        step();
        chk("stall_valid_g7", 64'(x_valid), 64'b1100);
        chk("stall_done_g7", 64'(tile_done), 64'd0);
        step();
        chk("stall_done_g8", 64'(tile_done), 64'd1);
        chk("stall_xout_g8", x_out, v4(5, 6, 7, 8));
        step();
        chk("stall_done_g9", 64'(tile_done), 64'd0);
        chk("stall_busy_g9", 64'(busy), 64'd0);

        // DRAIN blocks a continuously valid upstream
        drive(v4(1, 1, 1, 1), 1'b1, 1'b0);
        step();
        drive(v4(2, 2, 2, 2), 1'b1, 1'b1);
        step();
        drive(v4(3, 3, 3, 3), 1'b1, 1'b0);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("drain_inrdy_%0d", i), 64'(in_ready), 64'd0);
            step();
        end
        chk("drain_busy_fall", 64'(busy), 64'd0);
        chk("drain_inrdy_back", 64'(in_ready), 64'd1);
        step();
        chk("drain_next_busy", 64'(busy), 64'd1);
        chk("drain_next_cnt", 64'(vec_cnt), 64'd1);
        chk("drain_next_row0", 64'(x_out[15:0]), 64'd3);
        drive(v4(4, 4, 4, 4), 1'b1, 1'b1);
        step();
        chk("drain_next_cnt2", 64'(vec_cnt), 64'd2);
        idle();
        wait_done("drain_next_done", 3);
        step();
        chk("drain_next_idle", 64'(busy), 64'd0);

        // Single-vector tile
        drive(v4(9, 9, 9, 9), 1'b1, 1'b1);
        step();
        idle();
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_inrdy", 64'(in_ready), 64'd0);
        chk("single_cnt", 64'(vec_cnt), 64'd1);
        chk("single_last_j1", 64'(x_last), 64'b0001);
        step();
        chk("single_last_j2", 64'(x_last), 64'b0010);
        step();
        chk("single_last_j3", 64'(x_last), 64'b0100);
        chk("single_done_j3", 64'(tile_done), 64'd0);
        step();
        chk("single_last_j4", 64'(x_last), 64'b1000);
        chk("single_done_j4", 64'(tile_done), 64'd1);
        chk("single_xout_j4", x_out, v4(9, 9, 9, 9));
        step();
        chk("single_idle", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of DRAIN
        drive(v4(1, 2, 3, 4), 1'b1, 1'b1);
        step();
        idle();
        step();
        chk("arst_pre_busy", 64'(busy), 64'd1);
        chk("arst_pre_valid", 64'(x_valid), 64'b0010);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_xout", x_out, 64'd0);
        chk("arst_valid", 64'(x_valid), 64'd0);
        chk("arst_last", 64'(x_last), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_cnt", 64'(vec_cnt), 64'd0);
        #1 rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (tile_done === 1'b1) pulses++;
        end
        chk("arst_no_done", 64'(pulses), 64'd0);
        run_basic("s6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/x_skew_feeder.md
Name: x_skew_feeder

Overview:
- Upstream stage of the systolic PE array: accepts one X column vector (ROWS lanes) per cycle and delivers it to the array's left-edge PEs with a diagonal skew.
- Lane r is delayed r extra cycles, so the X element seen by row r lines up with the partial sums flowing down the array.
- Drives each row's Xin / valid_in_data / can_use.
- Tracks tile boundaries and signals when the last skewed element has left the final row.

Parameters:
- DWIDTH, 16, data width of one X element; matches the PE data width.
- ROWS, 4, number of array rows (lanes); legal range 1..16.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_vec  input  ROWS*DWIDTH  X vector; lane r is in_vec[r*DWIDTH +: DWIDTH].
- in_valid  input  1  in_vec/in_last valid.
- in_last  input  1  this vector is the last of the tile.
- in_ready  output  1  feeder accepts a vector this cycle.
- out_ready  input  1  array advance enable; 0 = global stall.
- x_out  output  ROWS*DWIDTH  skewed X per row; lane r feeds row r Xin.
- x_valid  output  ROWS  per-row valid; drives PE valid_in_data.
- x_last  output  ROWS  per-row last-of-tile marker; drives PE can_use.
- busy  output  1  state != IDLE.
- tile_done  output  1  one-cycle pulse when the last element leaves row ROWS-1.
- vec_cnt  output  16  vectors accepted in the current tile.

Behaviour:
- Reset (async, rst_n=0), applied immediately:
  - all x_out, x_valid, x_last, skew registers and vec_cnt = 0; tile_done = 0; state = IDLE.
  - Reset mid-tile discards all in-flight data; no tile_done is issued for the discarded tile.
- Accept: acc = in_valid & in_ready.
  - in_ready = out_ready & (state != DRAIN).
  - Combinational from out_ready and state; no dependence on in_valid.
- Skew pipeline:
  - Lane r is a shift chain of r+1 registers holding {data, valid, last}.
  - The chain advances only when out_ready=1; with out_ready=0 every register holds, including outputs.
  - Stage 0 of each chain loads in_vec lane r, acc, and in_last&acc.
  - Non-accept cycles while advancing shift in a bubble: valid=0, last=0; data holds its previous value (don't-care).
  - Latency, out_ready held 1: a vector accepted at edge N appears on lane r at edge N+1+r, i.e. row 0 after 1 cycle and row ROWS-1 after ROWS cycles.
  - All lanes of one vector carry the same valid/last, skewed.
- State machine:
  - IDLE: acc&~in_last -> STREAM; acc&in_last -> DRAIN (single-vector tile).
  - STREAM: acc&in_last -> DRAIN; otherwise stay. Bubbles are legal.
  - DRAIN: no accepts. Leave to IDLE on the cycle tile_done is asserted.
- tile_done:
  - Asserted for exactly one cycle, registered: it rises with the edge at which x_last[ROWS-1]=1 and x_valid[ROWS-1]=1 first appear.
  - The pulse does not stretch during a stall: it is qualified by the advance that loaded that output.
- vec_cnt:
  - Increments on every acc; saturates at 16'hFFFF.
  - Cleared on the edge the state enters IDLE from DRAIN.
  - A new tile's first accept (from IDLE) loads 1.
- Back-to-back tiles: the next tile is accepted only after returning to IDLE. The minimum gap between the last vector of tile A and the first of tile B is ROWS+1 cycles at out_ready=1.
- ROWS=1: no skew; DRAIN lasts one cycle.
- Simultaneous in_valid and out_ready=0: no accept, no shift, state unchanged.

Test Plan:
- Skew/latency: ROWS=4, DWIDTH=16, out_ready=1. Send vectors {1,2,3,4} then {5,6,7,8} (last). Required:
  - row0 shows 1 then 5 at cycles +1,+2; row3 shows 4 then 8 at cycles +4,+5.
  - x_last[3]=1 only with value 8; tile_done pulses at +5; vec_cnt=2 before clearing.
- Bubble: send {1,1,1,1}, one idle cycle, then {2,2,2,2} last. Required: every row shows valid,0,valid spaced by one cycle; tile_done one cycle later than with no bubble.
- Stall: drop out_ready for 3 cycles mid-tile. Required:
  - in_ready=0 during the stall; all x_out/x_valid frozen.
  - Output sequence identical to the unstalled run, shifted by 3 cycles; tile_done still a single pulse.
- DRAIN blocking: assert in_valid continuously across the tile end. Required: in_ready=0 for ROWS cycles after the last accept; the next tile's first vector is accepted the cycle after busy falls.
- Single-vector tile: in_last on the first vector {9,9,9,9}. Required: IDLE->DRAIN directly; x_last set on all rows with skew; tile_done at +4.
- Async reset mid-DRAIN: pulse rst_n low between clock edges. Required: outputs clear immediately; busy=0; no tile_done; the subsequent tile behaves as in scenario 1.
